aes_req_arbiter: RTL and testbench

//  Shares one AES core (aes_controller + round pipeline) among N_REQ requesters.

---
 rtl/aes_req_arbiter_pkg.sv | 23 ++
 rtl/aes_req_arbiter_if.sv | 35 +++
 rtl/aes_tag_fifo.sv | 70 +++++++
 rtl/aes_req_arbiter.sv | 177 +++++++++++++++++
 tb/tb_aes_req_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_req_arbiter_pkg.sv
// Shared types and constants for the AES request arbiter.
//   in_packet_t : packet presented by a requester and forwarded to the AES core
//   arb_state_e : arbiter FSM states
package aes_req_arbiter_pkg;

    localparam int AES_PIPE_DEPTH = 11;
    localparam int AES_BLK_W      = 128;

    typedef struct packed {
        logic                 valid;
        logic                 set_key;
        logic [AES_BLK_W-1:0] data;
    } in_packet_t;

    typedef enum logic [2:0] {
        ST_ISSUE,
        ST_DRAIN,
        ST_KEY_ISSUE,
        ST_KEY_WAIT_HI,
        ST_KEY_WAIT_LO
    } arb_state_e;

endpackage

// File: rtl/aes_req_arbiter_if.sv
// Bus bundle between the requesters/AES core (master side) and the arbiter (slave side).
//   req_pkt/req_ready           : per-requester packet and one-hot accept
//   core_pkt                    : registered packet towards the AES core
//   key_busy                    : core round-key load in progress
//   core_out_valid/core_out_data: core result
//   rsp_valid/rsp_data          : one-hot result strobe and data back to requesters
//   busy/err_orphan             : status
interface aes_req_arbiter_if
    import aes_req_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) ();

    in_packet_t [N_REQ-1:0]  req_pkt;
    logic [N_REQ-1:0]        req_ready;
    in_packet_t              core_pkt;
    logic                    key_busy;
    logic                    core_out_valid;
    logic [AES_BLK_W-1:0]    core_out_data;
    logic [N_REQ-1:0]        rsp_valid;
    logic [AES_BLK_W-1:0]    rsp_data;
    logic                    busy;
    logic                    err_orphan;

    modport master (
        output req_pkt, key_busy, core_out_valid, core_out_data,
        input  req_ready, core_pkt, rsp_valid, rsp_data, busy, err_orphan
    );

    modport slave (
        input  req_pkt, key_busy, core_out_valid, core_out_data,
        output req_ready, core_pkt, rsp_valid, rsp_data, busy, err_orphan
    );

endinterface

// File: rtl/aes_tag_fifo.sv
// Synchronous tag FIFO holding the requester ID of every block in flight in the core.
// Its occupancy is the arbiter's in-flight count.
//   push/push_id : store an ID at the tail (ignored when full)
//   pop/head_id  : drop the head ID (ignored when empty); head_id is the current head
//   full/empty   : occupancy flags
//   count        : number of stored IDs
module aes_tag_fifo #(
    parameter  int DEPTH = 11,
    parameter  int W     = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_id,
    input  logic             pop,
    output logic [W-1:0]     head_id,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head_id = mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_id;
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES core among N_REQ requesters. Round-robin grants at most one packet
// per cycle onto the core input, tags each data block with its requester ID and
// routes core results back. Key packets wait until the pipeline is empty and the
// core's key load has completed before normal issue resumes.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave modport of aes_req_arbiter_if (requests, core, responses, status)
module aes_req_arbiter
    import aes_req_arbiter_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int PIPE_DEPTH = AES_PIPE_DEPTH,
    localparam int ID_W       = $clog2(N_REQ),
    localparam int CNT_W      = $clog2(PIPE_DEPTH + 1)
) (
    input logic              clk,
    input logic              rst_n,
    aes_req_arbiter_if.slave bus
);

    arb_state_e           state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      key_id_q, key_id_d;
    in_packet_t           core_pkt_q, core_pkt_d;
    logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [AES_BLK_W-1:0] rsp_data_q, rsp_data_d;
    logic                 err_orphan_q, err_orphan_d;

    logic [N_REQ-1:0]     req_vec;
    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    logic [ID_W-1:0]      idx_w;
    logic [N_REQ-1:0]     ready;
    logic                 xfer;
    logic [ID_W-1:0]      gnt_id;
    in_packet_t           gnt_pkt;

    logic                 push, pop, fifo_full, fifo_empty;
    logic [ID_W-1:0]      head_id;
    logic [CNT_W-1:0]     inflight;

    aes_tag_fifo #(
        .DEPTH (PIPE_DEPTH),
        .W     (ID_W)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .push_id (gnt_id),
        .pop     (pop),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (inflight)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_vec[i] = bus.req_pkt[i].valid;
        end
    end

    // Scan from the farthest offset down to rr_ptr itself, so the last hit is the
    // first valid requester at or after rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx_w     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_w = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (req_vec[idx_w]) begin
                win_found = 1'b1;
                win_id    = idx_w;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        key_id_d   = key_id_q;
        rr_ptr_d   = rr_ptr_q;
        ready      = '0;
        gnt_id     = win_id;
        core_pkt_d = core_pkt_q;
        core_pkt_d.valid = 1'b0;

        unique case (state_q)
            ST_ISSUE: begin
                if (win_found) begin
                    if (!bus.req_pkt[win_id].set_key) begin
                        ready[win_id] = ~fifo_full;
                    end else if (inflight == '0) begin
                        ready[win_id] = 1'b1;
                    end else begin
                        key_id_d = win_id;
                        state_d  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (inflight == '0) begin
                    state_d = ST_KEY_ISSUE;
                end
            end
            ST_KEY_ISSUE: begin
                gnt_id          = key_id_q;
                ready[key_id_q] = req_vec[key_id_q];
            end
            ST_KEY_WAIT_HI: begin
                if (bus.key_busy) begin
                    state_d = ST_KEY_WAIT_LO;
                end
            end
            ST_KEY_WAIT_LO: begin
                if (!bus.key_busy) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase

        gnt_pkt = bus.req_pkt[gnt_id];
        xfer    = |ready;
        push    = xfer & ~gnt_pkt.set_key;

        if (xfer) begin
            rr_ptr_d         = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
            core_pkt_d       = gnt_pkt;
            core_pkt_d.valid = 1'b1;
            if (gnt_pkt.set_key) begin
                state_d = ST_KEY_WAIT_HI;
            end else if (state_q == ST_KEY_ISSUE) begin
                // The drained requester swapped its key for a data block; resume normal issue.
                state_d = ST_ISSUE;
            end
        end
    end

    // An orphan result (nothing in flight) only raises the sticky error; it never pops.
    always_comb begin
        pop          = bus.core_out_valid & ~fifo_empty;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        err_orphan_d = err_orphan_q | (bus.core_out_valid & fifo_empty);
        if (pop) begin
            rsp_valid_d[head_id] = 1'b1;
            rsp_data_d           = bus.core_out_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ISSUE;
            rr_ptr_q     <= '0;
            key_id_q     <= '0;
            core_pkt_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            key_id_q     <= key_id_d;
            core_pkt_q   <= core_pkt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.core_pkt   = core_pkt_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.err_orphan = err_orphan_q;
    assign bus.busy       = (state_q != ST_ISSUE) || (inflight != '0);

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed testbench for aes_req_arbiter (N_REQ=4, PIPE_DEPTH=11).
module tb_aes_req_arbiter;
    import aes_req_arbiter_pkg::*;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    aes_req_arbiter_if #(.N_REQ(4)) bus ();

    aes_req_arbiter #(
        .N_REQ      (4),
        .PIPE_DEPTH (11)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic k, input logic [127:0] d);
        bus.req_pkt[i].valid   = v;
        bus.req_pkt[i].set_key = k;
        bus.req_pkt[i].data    = d;
    endtask

    // One core result, sampled on the next edge; registered response visible on return.
    task automatic retire(input logic [127:0] d);
        bus.core_out_valid = 1'b1;
        bus.core_out_data  = d;
        step();
        bus.core_out_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) bus.req_pkt[i] = '0;
        bus.key_busy       = 1'b0;
        bus.core_out_valid = 1'b0;
        bus.core_out_data  = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_core_pkt_valid", bus.core_pkt.valid, 0);
        check("rst_core_pkt_data",  bus.core_pkt.data, 0);
        check("rst_req_ready",      bus.req_ready, 0);
        check("rst_rsp_valid",      bus.rsp_valid, 0);
        check("rst_rsp_data",       bus.rsp_data, 0);
        check("rst_busy",           bus.busy, 0);
        check("rst_err_orphan",     bus.err_orphan, 0);
        #9 rst_n = 1'b1;
        step();

        // 1: all four request data; round-robin grants 0,1,2,3,0,...
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 128'hA0 + 128'(i));
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t1_ready", bus.req_ready, 128'(1 << (k % 4)));
            step();
            check("t1_core_valid", bus.core_pkt.valid, 1);
            check("t1_core_data",  bus.core_pkt.data, 128'hA0 + 128'(k % 4));
        end
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, '0);
        #1;
        check("t1_ready_idle", bus.req_ready, 0);
        step();
        check("t1_core_valid_low", bus.core_pkt.valid, 0);
        check("t1_core_data_hold", bus.core_pkt.data, 128'hA3);
        check("t1_busy", bus.busy, 1);
        for (int k = 0; k < 8; k++) begin
            retire(128'h100 + 128'(k));
            check("t1_rsp_valid", bus.rsp_valid, 128'(1 << (k % 4)));
            check("t1_rsp_data",  bus.rsp_data, 128'h100 + 128'(k));
        end
        step();
        check("t1_rsp_valid_low", bus.rsp_valid, 0);
        check("t1_busy_idle", bus.busy, 0);

        // 2: req1 streams; the 12th block waits for the first retire
        set_req(1, 1'b1, 1'b0, 128'hB00);
        for (int k = 0; k < 11; k++) begin
            #1;
            check("t2_ready", bus.req_ready, 128'h2);
            step();
        end
        #1;
        check("t2_full_ready", bus.req_ready, 0);
        step();
        #1;
        check("t2_full_ready_hold", bus.req_ready, 0);
        retire(128'hC00);
        check("t2_first_rsp", bus.rsp_valid, 128'h2);
        #1;
        check("t2_refill_ready", bus.req_ready, 128'h2);
        step();
        check("t2_refill_core_valid", bus.core_pkt.valid, 1);
        set_req(1, 1'b0, 1'b0, '0);
        for (int k = 0; k < 11; k++) begin
            retire(128'hC01 + 128'(k));
            check("t2_rsp_valid", bus.rsp_valid, 128'h2);
            check("t2_rsp_data",  bus.rsp_data, 128'hC01 + 128'(k));
        end
        step();
        check("t2_busy_idle", bus.busy, 0);

        // 3: key request from req2 with 5 blocks in flight
        set_req(0, 1'b1, 1'b0, 128'hD0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t3_fill_ready", bus.req_ready, 128'h1);
            step();
        end
        set_req(0, 1'b0, 1'b0, '0);
        set_req(2, 1'b1, 1'b1, KEY);
        set_req(3, 1'b1, 1'b0, 128'hE0);
        #1;
        check("t3_key_blocked", bus.req_ready, 0);
        step();
        check("t3_drain_busy", bus.busy, 1);
        for (int k = 0; k < 5; k++) begin
            bus.core_out_valid = 1'b1;
            bus.core_out_data  = 128'hF0 + 128'(k);
            #1;
            check("t3_drain_ready", bus.req_ready, 0);
            step();
            bus.core_out_valid = 1'b0;
            check("t3_drain_rsp", bus.rsp_valid, 128'h1);
        end
        #1;
        check("t3_drain_exit_ready", bus.req_ready, 0);
        check("t3_drain_core_idle", bus.core_pkt.valid, 0);
        step();
        #1;
        check("t3_key_ready", bus.req_ready, 128'h4);
        step();
        check("t3_key_core_valid", bus.core_pkt.valid, 1);
        check("t3_key_core_setkey", bus.core_pkt.set_key, 1);
        check("t3_key_core_data", bus.core_pkt.data, KEY);
        set_req(2, 1'b0, 1'b0, '0);
        #1;
        check("t3_wait_hi_ready", bus.req_ready, 0);
        step();
        check("t3_wait_core_idle", bus.core_pkt.valid, 0);
        bus.key_busy = 1'b1;
        #1;
        check("t3_keybusy_ready", bus.req_ready, 0);
        step();
        step();
        bus.key_busy = 1'b0;
        #1;
        check("t3_wait_lo_ready", bus.req_ready, 0);
        step();
        #1;
        check("t3_resume_ready", bus.req_ready, 128'h8);
        step();
        check("t3_resume_core_data", bus.core_pkt.data, 128'hE0);
        set_req(3, 1'b0, 1'b0, '0);
        retire(128'h1234);
        check("t3_resume_rsp", bus.rsp_valid, 128'h8);

        // 4: key at inflight=0 reaches the core one cycle after the handshake
        set_req(1, 1'b1, 1'b1, 128'h55);
        #1;
        check("t4_key_ready", bus.req_ready, 128'h2);
        step();
        check("t4_core_valid", bus.core_pkt.valid, 1);
        check("t4_core_setkey", bus.core_pkt.set_key, 1);
        set_req(1, 1'b0, 1'b0, '0);
        step();
        check("t4_core_valid_low", bus.core_pkt.valid, 0);
        check("t4_busy_wait", bus.busy, 1);
        bus.key_busy = 1'b1;
        step();
        bus.key_busy = 1'b0;
        step();
        check("t4_busy_done", bus.busy, 0);

        // 5: issue and retire in the same cycle for 20 cycles with 3 in flight
        set_req(2, 1'b1, 1'b0, 128'h200);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t5_fill_ready", bus.req_ready, 128'h4);
            step();
        end
        for (int k = 0; k < 20; k++) begin
            set_req(2, 1'b1, 1'b0, 128'h300 + 128'(k));
            bus.core_out_valid = 1'b1;
            bus.core_out_data  = 128'h400 + 128'(k);
            #1;
            check("t5_ready", bus.req_ready, 128'h4);
            step();
            check("t5_core_data", bus.core_pkt.data, 128'h300 + 128'(k));
            check("t5_rsp_valid", bus.rsp_valid, 128'h4);
            check("t5_rsp_data",  bus.rsp_data, 128'h400 + 128'(k));
        end
        bus.core_out_valid = 1'b0;
        set_req(2, 1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            retire(128'h500 + 128'(k));
            check("t5_tail_rsp", bus.rsp_valid, 128'h4);
            check("t5_tail_busy", bus.busy, (k < 2) ? 128'h1 : 128'h0);
        end

        // 6: reset with 6 in flight, then a stray result
        set_req(0, 1'b1, 1'b0, 128'h600);
        for (int k = 0; k < 6; k++) begin
            #1;
            check("t6_fill_ready", bus.req_ready, 128'h1);
            step();
        end
        set_req(0, 1'b0, 1'b0, '0);
        #1;
        check("t6_busy_pre", bus.busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_core_valid", bus.core_pkt.valid, 0);
        check("t6_rst_core_data", bus.core_pkt.data, 0);
        check("t6_rst_rsp_valid", bus.rsp_valid, 0);
        check("t6_rst_rsp_data", bus.rsp_data, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_err", bus.err_orphan, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        retire(128'h777);
        check("t6_orphan_err", bus.err_orphan, 1);
        check("t6_orphan_rsp", bus.rsp_valid, 0);
        step();
        check("t6_orphan_sticky", bus.err_orphan, 1);
        check("t6_orphan_busy", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
